// File: rtl/ttc_irq_ctrl22_pkg.sv
// Shared definitions for the timer interrupt controller: register offsets,
// default sizing and the priority encoder used for the ID register.
package ttc_irq_pkg22;

  localparam int NUM_SRC_DEF = 3;
  localparam int OVR_W_DEF   = 4;

  localparam logic [7:0] ADDR_RAW  = 8'h00;
  localparam logic [7:0] ADDR_PEND = 8'h04;
  localparam logic [7:0] ADDR_EN   = 8'h08;
  localparam logic [7:0] ADDR_MODE = 8'h0C;
  localparam logic [7:0] ADDR_STAT = 8'h10;
  localparam logic [7:0] ADDR_ID   = 8'h14;
  localparam logic [7:0] ADDR_OVR  = 8'h18;

  // 1-based index of the lowest set bit (lowest number = highest priority), 0 if none.
  function automatic logic [3:0] lowest_id(input logic [7:0] vec);
    logic [3:0] id;
    id = '0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) id = 4'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/ttc_irq_ctrl22_if.sv
// APB slave bus of the timer interrupt controller.
interface ttc_irq_ctrl22_if;

  logic        psel22;
  logic        penable22;
  logic        pwrite22;
  logic [7:0]  paddr22;
  logic [31:0] pwdata22;
  logic [31:0] prdata22;

  modport master (
    output psel22, penable22, pwrite22, paddr22, pwdata22,
    input  prdata22
  );

  modport slave (
    input  psel22, penable22, pwrite22, paddr22, pwdata22,
    output prdata22
  );

endinterface

// File: rtl/ttc_irq_ctrl22_src.sv
// One interrupt source: edge/level capture, sticky pending bit and a
// saturating overrun counter.
module ttc_irq_src22
  import ttc_irq_pkg22::*;
#(
  parameter int OVR_W = OVR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             int_in,
  input  logic             mode,
  input  logic             clear,
  input  logic             clear_ovr,
  output logic             pending,
  output logic [OVR_W-1:0] ovr_cnt
);

  logic int_d;
  logic set;

  assign set = mode ? int_in : (int_in & ~int_d);

  // int_d keeps tracking the input during reset so a line held high is not an edge afterwards.
  always_ff @(posedge clk) begin
    int_d <= int_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
      ovr_cnt <= '0;
    end else begin
      pending <= set | (pending & ~clear);
      if (clear_ovr) begin
        ovr_cnt <= '0;
      end else if (set && pending && !mode && (ovr_cnt != {OVR_W{1'b1}})) begin
        ovr_cnt <= ovr_cnt + OVR_W'(1);
      end
    end
  end

endmodule

// File: rtl/ttc_irq_ctrl22.sv
// Timer interrupt controller top: APB register file, per-source capture
// instances, priority ID encoder and the registered CPU interrupt.
module ttc_irq_ctrl22
  import ttc_irq_pkg22::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int OVR_W   = OVR_W_DEF
) (
  input  logic               pclk22,
  input  logic               n_p_reset22,
  ttc_irq_ctrl22_if.slave    apb,
  input  logic [NUM_SRC-1:0] ttc_int22,
  output logic               irq22
);

  logic [7:0]               addr;
  logic                     wr;
  logic [NUM_SRC-1:0]       enable;
  logic [NUM_SRC-1:0]       mode;
  logic [NUM_SRC-1:0]       pending;
  logic [NUM_SRC-1:0]       pend_clr;
  logic [NUM_SRC-1:0]       status;
  logic [NUM_SRC*OVR_W-1:0] ovr_all;
  logic                     ovr_clr;
  logic [3:0]               id;
  logic                     unused_bits;

  assign addr        = {apb.paddr22[7:2], 2'b00};
  assign wr          = apb.psel22 & apb.penable22 & apb.pwrite22;
  assign pend_clr    = (wr && addr == ADDR_PEND) ? apb.pwdata22[NUM_SRC-1:0] : '0;
  assign ovr_clr     = wr && (addr == ADDR_OVR);
  assign status      = pending & enable;
  assign id          = lowest_id(8'(status));
  assign unused_bits = ^{apb.paddr22[1:0], apb.pwdata22};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    ttc_irq_src22 #(.OVR_W(OVR_W)) u_src (
      .clk       (pclk22),
      .rst_n     (n_p_reset22),
      .int_in    (ttc_int22[i]),
      .mode      (mode[i]),
      .clear     (pend_clr[i]),
      .clear_ovr (ovr_clr),
      .pending   (pending[i]),
      .ovr_cnt   (ovr_all[i*OVR_W +: OVR_W])
    );
  end

  always_ff @(posedge pclk22) begin
    if (!n_p_reset22) begin
      enable <= '0;
      mode   <= '0;
      irq22  <= 1'b0;
    end else begin
      if (wr && addr == ADDR_EN)   enable <= apb.pwdata22[NUM_SRC-1:0];
      if (wr && addr == ADDR_MODE) mode   <= apb.pwdata22[NUM_SRC-1:0];
      irq22 <= |status;
    end
  end

  always_comb begin
    apb.prdata22 = '0;
    if (apb.psel22 && !apb.pwrite22) begin
      case (addr)
        ADDR_RAW:  apb.prdata22 = 32'(ttc_int22);
        ADDR_PEND: apb.prdata22 = 32'(pending);
        ADDR_EN:   apb.prdata22 = 32'(enable);
        ADDR_MODE: apb.prdata22 = 32'(mode);
        ADDR_STAT: apb.prdata22 = 32'(status);
        ADDR_ID:   apb.prdata22 = 32'(id);
        ADDR_OVR:  apb.prdata22 = 32'(ovr_all);
        default:   apb.prdata22 = '0;
      endcase
    end
  end

endmodule
